// File: rtl/bist_pkg.sv
// Shared types and constants for the scan BIST controller and its LFSR/MISR step unit.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_DONE
    } bist_state_e;

    // Selects whether the step unit produces patterns or compresses responses.
    typedef enum logic {
        MODE_GEN,
        MODE_COMP
    } lfsr_mode_e;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form.
    localparam logic [15:0] BIST_POLY = 16'hB400;
    localparam logic [15:0] BIST_SEED = 16'hACE1;

    // Counter width for a 0..bound-1 range, never narrower than one bit.
    function automatic int cnt_width(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/scan_bist_ctrl_if.sv
// Handshake and scan-bus bundle between the BIST controller and the core under test.
interface scan_bist_ctrl_if #(
    parameter int PI_W = 7,
    parameter int PO_W = 7
);

    logic            start;
    logic            scan_en;
    logic            scan_in;
    logic            scan_out;
    logic [PI_W-1:0] pi;
    logic [PO_W-1:0] po;
    logic [15:0]     golden;
    logic            busy;
    logic            done;
    logic            pass;
    logic [15:0]     signature;

    modport master (
        input  start, scan_out, po, golden,
        output scan_en, scan_in, pi, busy, done, pass, signature
    );

    modport slave (
        output start, scan_out, po, golden,
        input  scan_en, scan_in, pi, busy, done, pass, signature
    );

endinterface

// File: rtl/bist_lfsr16.sv
// Combinational single step of the 16-bit BIST register: Fibonacci pattern
// generator or Galois MISR, sharing one polynomial.
module bist_lfsr16
    import bist_pkg::*;
(
    input  lfsr_mode_e  mode,
    input  logic [15:0] state_cur,
    input  logic [15:0] data_in,
    output logic [15:0] state_nxt
);

    logic [15:0] fib_taps;
    logic        fib_feedback;

    // The Fibonacci tap mask is the bit-reverse of the Galois polynomial.
    always_comb begin
        fib_taps = '0;
        for (int i = 0; i < 16; i++) begin
            fib_taps[i] = BIST_POLY[15-i];
        end
    end

    // Advance the register by one step in the selected form.
    always_comb begin
        fib_feedback = ^(state_cur & fib_taps);
        state_nxt    = '0;
        case (mode)
            MODE_GEN: state_nxt = {fib_feedback, state_cur[15:1]};
            default:  state_nxt = ({1'b0, state_cur[15:1]}
                                   ^ (state_cur[0] ? BIST_POLY : 16'h0000))
                                  ^ data_in;
        endcase
    end

endmodule

// File: rtl/scan_bist_ctrl.sv
// Scan BIST controller: shifts LFSR patterns into the core chain, captures
// functional responses, and compacts everything into a 16-bit MISR signature.
module scan_bist_ctrl
    import bist_pkg::*;
#(
    parameter int CHAIN_LEN = 6,
    parameter int PI_W      = 7,
    parameter int PO_W      = 7,
    parameter int NUM_PAT   = 64
) (
    input logic              CK,
    input logic              rstn,
    scan_bist_ctrl_if.master bus
);

    localparam int SC_W = cnt_width(CHAIN_LEN);
    localparam int PC_W = cnt_width(NUM_PAT);
    localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(CHAIN_LEN - 1);
    localparam logic [PC_W-1:0] PAT_LAST   = PC_W'(NUM_PAT - 1);

    bist_state_e     state;
    bist_state_e     state_next;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_step;
    logic [15:0]     misr;
    logic [15:0]     misr_step;
    logic [15:0]     misr_data;
    logic [SC_W-1:0] shift_cnt;
    logic [PC_W-1:0] pattern_cnt;
    logic [PI_W-1:0] pi_q;
    logic            last_shift;
    logic            last_pattern;
    logic            scan_en_c;
    logic            scan_in_c;
    logic            busy_c;
    logic            done_c;

    assign last_shift   = (shift_cnt == SHIFT_LAST);
    assign last_pattern = (pattern_cnt == PAT_LAST);

    bist_lfsr16 u_pattern_gen (
        .mode      (MODE_GEN),
        .state_cur (lfsr),
        .data_in   (16'h0000),
        .state_nxt (lfsr_step)
    );

    bist_lfsr16 u_misr (
        .mode      (MODE_COMP),
        .state_cur (misr),
        .data_in   (misr_data),
        .state_nxt (misr_step)
    );

    // State register.
    always_ff @(posedge CK or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencing: shift a pattern, capture once, repeat, then unload the last response.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (bus.start)   state_next = ST_SHIFT;
            ST_SHIFT:         if (last_shift)  state_next = ST_CAPTURE;
            ST_CAPTURE:       state_next = last_pattern ? ST_UNLOAD : ST_SHIFT;
            ST_UNLOAD:        if (last_shift)  state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Per-state control outputs toward the core and the requester.
    always_comb begin
        scan_en_c = 1'b0;
        scan_in_c = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            ST_SHIFT: begin
                scan_en_c = 1'b1;
                scan_in_c = lfsr[0];
                busy_c    = 1'b1;
            end
            ST_CAPTURE: busy_c = 1'b1;
            ST_UNLOAD: begin
                scan_en_c = 1'b1;
                busy_c    = 1'b1;
            end
            ST_DONE:  done_c = 1'b1;
            default: ;
        endcase
    end

    // MISR input: chain output while shifting (the first pattern unloads stale core state, so it is masked), primary outputs at capture.
    always_comb begin
        misr_data = '0;
        case (state)
            ST_SHIFT:   misr_data[0]        = (pattern_cnt != '0) && bus.scan_out;
            ST_CAPTURE: misr_data[PO_W-1:0] = bus.po;
            ST_UNLOAD:  misr_data[0]        = bus.scan_out;
            default: ;
        endcase
    end

    // Datapath registers: pattern LFSR, MISR, counters and the held primary-input vector.
    always_ff @(posedge CK or negedge rstn) begin
        if (!rstn) begin
            lfsr        <= BIST_SEED;
            misr        <= '0;
            shift_cnt   <= '0;
            pattern_cnt <= '0;
            pi_q        <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        lfsr        <= BIST_SEED;
                        misr        <= '0;
                        shift_cnt   <= '0;
                        pattern_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    lfsr <= lfsr_step;
                    misr <= misr_step;
                    if (last_shift) begin
                        shift_cnt <= '0;
                        pi_q      <= lfsr_step[PI_W-1:0];
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    misr <= misr_step;
                    if (!last_pattern) begin
                        pattern_cnt <= pattern_cnt + 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    misr <= misr_step;
                    if (last_shift) begin
                        shift_cnt <= '0;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.scan_en   = scan_en_c;
    assign bus.scan_in   = scan_in_c;
    assign bus.pi        = pi_q;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.signature = misr;
    assign bus.pass      = done_c && (misr == bus.golden);

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Directed bench for scan_bist_ctrl with a small 6-bit scan core model and a
// behavioural signature reference.
module tb_scan_bist_ctrl;

    localparam int CHAIN_LEN = 6;
    localparam int PI_W      = 7;
    localparam int PO_W      = 7;
    localparam int NUM_PAT   = 4;
    localparam int DONE_CYC  = NUM_PAT * (CHAIN_LEN + 1) + CHAIN_LEN + 1;
    localparam int LAST_BUSY = DONE_CYC - 1;

    logic        CK       = 1'b0;
    logic        rstn     = 1'b0;
    logic [5:0]  core     = '0;
    logic        use_core = 1'b1;
    logic        flip     = 1'b0;
    int          n_compared = 0;
    int          n_mismatch = 0;
    logic [15:0] ref_sig;
    logic [15:0] ref_sig_flip;
    logic [15:0] ref_sig_tie0;
    logic [15:0] sig_a;
    logic [15:0] sig_b;
    logic [6:0]  ref_pi;

    scan_bist_ctrl_if #(.PI_W(PI_W), .PO_W(PO_W)) bus ();

    scan_bist_ctrl #(
        .CHAIN_LEN (CHAIN_LEN),
        .PI_W      (PI_W),
        .PO_W      (PO_W),
        .NUM_PAT   (NUM_PAT)
    ) dut (
        .CK   (CK),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 CK = ~CK;

    // Core under test: a 6-bit scan chain whose functional capture XORs in the primary inputs.
    assign bus.scan_out = (use_core ? core[0] : 1'b0) ^ flip;
    assign bus.po       = use_core ? (bus.pi ^ {1'b0, core}) : '0;

    // Core state register: shift when scan-enabled, otherwise functional load.
    always @(posedge CK) begin
        if (bus.scan_en) core <= {bus.scan_in, core[5:1]};
        else             core <= core ^ bus.pi[5:0];
    end

    function automatic logic [15:0] fib_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [15:0] gal_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [6:0] model_pi();
        logic [15:0] l;
        l = 16'hACE1;
        for (int s = 0; s < CHAIN_LEN; s++) l = fib_step(l);
        return l[6:0];
    endfunction

    // Whole-run reference: cycle index c follows the controller's numbering (first SHIFT is cycle 1).
    function automatic logic [15:0] model_signature(input bit core_on, input int flip_at);
        logic [15:0] l;
        logic [15:0] m;
        logic [5:0]  cm;
        logic [6:0]  pm;
        logic        so;
        int          c;
        l = 16'hACE1; m = '0; cm = '0; pm = '0; c = 1;
        for (int p = 0; p < NUM_PAT; p++) begin
            for (int s = 0; s < CHAIN_LEN; s++) begin
                so = (core_on ? cm[0] : 1'b0) ^ (c == flip_at);
                m  = gal_step(m) ^ {15'd0, (p == 0) ? 1'b0 : so};
                cm = {l[0], cm[5:1]};
                l  = fib_step(l);
                c++;
            end
            pm = l[6:0];
            m  = gal_step(m) ^ {9'd0, core_on ? (pm ^ {1'b0, cm}) : 7'd0};
            cm = cm ^ pm[5:0];
            c++;
        end
        for (int s = 0; s < CHAIN_LEN; s++) begin
            so = (core_on ? cm[0] : 1'b0) ^ (c == flip_at);
            m  = gal_step(m) ^ {15'd0, so};
            cm = {1'b0, cm[5:1]};
            c++;
        end
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_scan_en"},   bus.scan_en,   0);
        checkOutput({tag, "_scan_in"},   bus.scan_in,   0);
        checkOutput({tag, "_pi"},        bus.pi,        0);
        checkOutput({tag, "_busy"},      bus.busy,      0);
        checkOutput({tag, "_done"},      bus.done,      0);
        checkOutput({tag, "_pass"},      bus.pass,      0);
        checkOutput({tag, "_signature"}, bus.signature, 0);
    endtask

    // One run from IDLE/DONE: entered mid-cycle 0, leaves mid-cycle DONE_CYC (or after an abort).
    task automatic applyStimulus(input bit hold_start, input int flip_at, input int abort_at,
                                 output logic [15:0] sig);
        logic [5:0] scan_in_ref;
        scan_in_ref = 6'b100001;
        sig = '0;
        bus.start = 1'b1;
        for (int c = 1; c <= DONE_CYC; c++) begin
            @(negedge CK);
            flip = (c == flip_at);
            if (!hold_start) bus.start = 1'b0;
            if (c == abort_at) begin
                rstn = 1'b0;
                #1;
                checkResetOutputs("abort");
                break;
            end
            checkOutput($sformatf("busy@%0d", c), bus.busy, c <= LAST_BUSY);
            checkOutput($sformatf("done@%0d", c), bus.done, c == DONE_CYC);
            checkOutput($sformatf("scan_en@%0d", c), bus.scan_en,
                        (c <= LAST_BUSY) && (c % (CHAIN_LEN + 1) != 0));
            if (c <= CHAIN_LEN) begin
                checkOutput($sformatf("scan_in@%0d", c), bus.scan_in, scan_in_ref[c-1]);
            end
            if (c == CHAIN_LEN + 1) begin
                checkOutput("pi@capture1", bus.pi, ref_pi);
            end
            if (c == DONE_CYC) sig = bus.signature;
        end
        flip = 1'b0;
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.golden = 16'h0000;
        ref_sig      = model_signature(1'b1, 0);
        ref_sig_flip = model_signature(1'b1, 10);
        ref_sig_tie0 = model_signature(1'b0, 0);
        ref_pi       = model_pi();

        repeat (2) @(negedge CK);
        checkResetOutputs("por");
        rstn = 1'b1;
        @(negedge CK);

        $display("[TB] run with core model, golden = reference");
        use_core   = 1'b1;
        bus.golden = ref_sig;
        applyStimulus(1'b0, 0, 0, sig_a);
        checkOutput("sig_core", sig_a, ref_sig);
        checkOutput("pass_match", bus.pass, 1);
        bus.golden = ref_sig ^ 16'h0001;
        #1;
        checkOutput("pass_golden_flip", bus.pass, 0);
        bus.golden = ref_sig;
        #1;
        checkOutput("pass_restore", bus.pass, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge CK);
            checkOutput("done_hold", bus.done, 1);
            checkOutput("sig_hold", bus.signature, ref_sig);
        end

        $display("[TB] run with scan_out and po tied low");
        use_core   = 1'b0;
        bus.golden = ref_sig_tie0;
        applyStimulus(1'b0, 0, 0, sig_a);
        checkOutput("sig_tie0", sig_a, ref_sig_tie0);
        checkOutput("pass_tie0", bus.pass, 1);

        $display("[TB] run with scan_out flipped at cycle 10");
        use_core   = 1'b1;
        bus.golden = ref_sig;
        applyStimulus(1'b0, 10, 0, sig_b);
        checkOutput("sig_flip", sig_b, ref_sig_flip);
        checkOutput("flip_differs", sig_b != ref_sig, 1);
        checkOutput("pass_flip", bus.pass, 0);

        $display("[TB] reset at cycle 15, then a clean run");
        applyStimulus(1'b0, 0, 15, sig_b);
        @(negedge CK);
        checkResetOutputs("in_reset");
        rstn = 1'b1;
        @(negedge CK);
        applyStimulus(1'b0, 0, 0, sig_b);
        checkOutput("sig_after_abort", sig_b, ref_sig);
        checkOutput("pass_after_abort", bus.pass, 1);

        $display("[TB] start held high across two runs");
        applyStimulus(1'b1, 0, 0, sig_a);
        checkOutput("sig_hold_run1", sig_a, ref_sig);
        applyStimulus(1'b1, 0, 0, sig_b);
        checkOutput("sig_hold_run2", sig_b, ref_sig);
        checkOutput("sig_runs_equal", sig_b, sig_a);
        bus.start = 1'b0;
        @(negedge CK);
        checkOutput("done_after_release", bus.done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/scan_bist_ctrl.md
SCAN_BIST_CTRL -- requirements
Module: scan_bist_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 6: scan-chain length of the core under test.
REQ-002 SHALL have parameter PI_W, default 7: core primary-input width.
REQ-003 SHALL have parameter PO_W, default 7: core primary-output width.
REQ-004 SHALL have parameter NUM_PAT, default 64: patterns per run (legal range 1..65535).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: CK input 1, rising-edge clock; rstn input 1, async assert, active low.
REQ-006 SHALL have these ports:
- start input 1: run request, sampled in IDLE/DONE.
- scan_en output 1: core shift enable.
- scan_in output 1: serial data into the core chain.
- scan_out input 1: serial data from the core chain.
- pi output PI_W: core primary inputs.
- po input PO_W: core primary outputs.
- golden input 16: expected signature.
- busy output 1: run in progress.
- done output 1: run complete.
- pass output 1: signature equals golden.
- signature output 16: MISR contents.

Function
REQ-007 SHALL implement FSM states IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
REQ-008 IDLE/DONE with start=1 SHALL go to SHIFT next cycle, seed LFSR=16'hACE1, clear MISR to 0, and clear the shift and pattern counters.
REQ-009 SHIFT SHALL last exactly CHAIN_LEN cycles with scan_en=1, scan_in=lfsr[0], and the LFSR advancing one step per cycle.
REQ-010 The LFSR SHALL be Fibonacci x^16+x^14+x^13+x^11+1, shifting right, feedback into bit 15.
REQ-011 On the last SHIFT cycle, pi SHALL load lfsr[PI_W-1:0] (post-advance value) and hold it through CAPTURE.
REQ-012 CAPTURE SHALL last one cycle with scan_en=0; the core state register loads functionally.
REQ-013 After CAPTURE the FSM SHALL go to SHIFT if pattern_cnt<NUM_PAT-1, else UNLOAD; pattern_cnt increments in CAPTURE.
REQ-014 UNLOAD SHALL last CHAIN_LEN cycles with scan_en=1, scan_in=0, and the LFSR frozen, then go to DONE.
REQ-015 The MISR SHALL be Galois with the same polynomial; each update is misr_next = step(misr) XOR data, with data zero-extended to 16 bits.
REQ-016 MISR data SHALL be scan_out in SHIFT (except during the first pattern, where it is masked to 0) and in UNLOAD; it SHALL be po in CAPTURE; the MISR holds in IDLE/DONE.
REQ-017 busy SHALL be 1 in SHIFT/CAPTURE/UNLOAD; done SHALL be 1 only in DONE; pass = done AND (signature==golden), evaluated combinationally.
REQ-018 Timing: with start sampled at cycle 0, DONE SHALL be entered at cycle NUM_PAT*(CHAIN_LEN+1)+CHAIN_LEN+1.
REQ-019 start SHALL be ignored while busy.
REQ-020 In DONE, start=0 SHALL hold DONE and its outputs indefinitely.
REQ-021 golden changing in DONE SHALL update pass in the same cycle.
REQ-022 NUM_PAT=1 SHALL give exactly one SHIFT/CAPTURE then UNLOAD.
REQ-023 Counter widths SHALL be $clog2 of the bound with no wrap: shift_cnt 0..CHAIN_LEN-1, pattern_cnt 0..NUM_PAT-1.

Reset
REQ-024 rstn=0 SHALL immediately force IDLE with outputs scan_en=0, scan_in=0, pi=0, busy=0, done=0, pass=0, signature=0, LFSR=16'hACE1, and counters 0.
REQ-025 Reset mid-run SHALL abort without completion; the first post-reset start SHALL begin a clean run identical to a run from power-up.

Structure
REQ-026 A shared package bist_pkg SHALL hold the state enum, the 16-bit polynomial constant 16'hB400, and the seed 16'hACE1.
REQ-027 The LFSR/MISR step SHALL be a sub-module bist_lfsr16 (mode input: generate or compress) instantiated twice.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- CHAIN_LEN=6, NUM_PAT=4, start pulse at cycle 0 -> busy cycles 1..34, done=1 at cycle 35, scan_en=0 exactly at cycles 7,14,21,28.
- After reset, start -> scan_in over cycles 1..6 equals the first 6 LSBs of the LFSR sequence from 16'hACE1 (1,0,0,0,0,1); pi at cycle 7 matches the reference model.
- Core model (6-bit shift register, po=0), scan_out tied 0 -> signature equals reference-model value; golden=that value -> pass=1; golden^1 -> pass=0 in the same cycle.
- Single-bit flip injected on scan_out at cycle 10 -> signature differs from the fault-free value, pass=0.
- rstn pulsed low at cycle 15 of a run -> outputs zero immediately; a fresh start yields a signature identical to an uninterrupted run.
- start held high through the whole run and into DONE -> no restart while busy; DONE to SHIFT next cycle, second signature identical to the first.
